// File: rtl/axi_pkg.sv
// Shared AXI definitions: arbiter state encoding and protocol constants.
package axi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } arb_state_t;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi4_if.sv
// AXI4 bundle. A transfer happens on every rising edge where valid and ready are both 1;
// valid must not depend on ready, and once raised it holds with stable payload until the transfer.
interface axi4_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 1
);
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;
    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ID_WIDTH-1:0]     arid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arvalid;
    logic                    arready;
    logic [ID_WIDTH-1:0]     rid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        output wdata, wstrb, wlast, wvalid, bready,
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  awready, wready, bid, bresp, bvalid,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        input  wdata, wstrb, wlast, wvalid, bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output awready, wready, bid, bresp, bvalid,
        output arready, rid, rdata, rresp, rlast, rvalid
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the side not served last.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant
);

    always_comb begin
        grant = 1'b0;
        case (req)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last;
            default: grant = 1'b0;
        endcase
    end

endmodule

// File: rtl/axi4_arbiter.sv
// Two-to-one AXI4 arbiter: one whole read or write transaction per grant, round-robin between IFU (m0) and LSU (m1).
module axi4_arbiter
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    axi4_if.slave      m0,
    axi4_if.slave      m1,
    axi4_if.master     s,
    output arb_state_t dbg_state
);

    arb_state_t state;
    logic       gnt;
    logic       last;
    logic       ar_done;
    logic       aw_done;
    logic [1:0] req;
    logic       pick;
    logic       pick_rd;

    assign req     = {m1.arvalid | m1.awvalid, m0.arvalid | m0.awvalid};
    assign pick_rd = pick ? m1.arvalid : m0.arvalid;
    assign dbg_state = state;

    rr_arb2 u_rr (
        .req   (req),
        .last  (last),
        .grant (pick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            gnt     <= 1'b0;
            last    <= 1'b1;
            ar_done <= 1'b0;
            aw_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        gnt     <= pick;
                        state   <= pick_rd ? RD : WR;
                        ar_done <= 1'b0;
                        aw_done <= 1'b0;
                    end
                end
                RD: begin
                    if (s.arvalid && s.arready) ar_done <= 1'b1;
                    if (s.rvalid && s.rready && s.rlast) begin
                        last  <= gnt;
                        state <= IDLE;
                    end
                end
                WR: begin
                    if (s.awvalid && s.awready) aw_done <= 1'b1;
                    if (s.bvalid && s.bready) begin
                        last  <= gnt;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic                    in_rd, in_wr;
    logic [ID_WIDTH-1:0]     ar_id, aw_id;
    logic [ADDR_WIDTH-1:0]   ar_addr, aw_addr;
    logic [7:0]              ar_len, aw_len;
    logic [2:0]              ar_size, aw_size;
    logic [1:0]              ar_burst, aw_burst;
    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH/8-1:0] w_strb;
    logic                    w_last, ar_valid, aw_valid, w_valid, r_ready, b_ready;

    assign in_rd = (state == RD);
    assign in_wr = (state == WR);

    // Everything the granted master drives; all zero while idle.
    always_comb begin
        ar_id = '0; ar_addr = '0; ar_len = '0; ar_size = '0; ar_burst = '0; ar_valid = 1'b0;
        aw_id = '0; aw_addr = '0; aw_len = '0; aw_size = '0; aw_burst = '0; aw_valid = 1'b0;
        w_data = '0; w_strb = '0; w_last = 1'b0; w_valid = 1'b0; r_ready = 1'b0; b_ready = 1'b0;
        if (state != IDLE) begin
            if (gnt) begin
                ar_id = m1.arid; ar_addr = m1.araddr; ar_len = m1.arlen;
                ar_size = m1.arsize; ar_burst = m1.arburst; ar_valid = m1.arvalid;
                aw_id = m1.awid; aw_addr = m1.awaddr; aw_len = m1.awlen;
                aw_size = m1.awsize; aw_burst = m1.awburst; aw_valid = m1.awvalid;
                w_data = m1.wdata; w_strb = m1.wstrb; w_last = m1.wlast; w_valid = m1.wvalid;
                r_ready = m1.rready; b_ready = m1.bready;
            end else begin
                ar_id = m0.arid; ar_addr = m0.araddr; ar_len = m0.arlen;
                ar_size = m0.arsize; ar_burst = m0.arburst; ar_valid = m0.arvalid;
                aw_id = m0.awid; aw_addr = m0.awaddr; aw_len = m0.awlen;
                aw_size = m0.awsize; aw_burst = m0.awburst; aw_valid = m0.awvalid;
                w_data = m0.wdata; w_strb = m0.wstrb; w_last = m0.wlast; w_valid = m0.wvalid;
                r_ready = m0.rready; b_ready = m0.bready;
            end
        end
    end

    assign s.arid    = ar_id;
    assign s.araddr  = ar_addr;
    assign s.arlen   = ar_len;
    assign s.arsize  = ar_size;
    assign s.arburst = ar_burst;
    assign s.arvalid = in_rd & ar_valid & ~ar_done;
    assign s.rready  = in_rd & r_ready;
    assign s.awid    = aw_id;
    assign s.awaddr  = aw_addr;
    assign s.awlen   = aw_len;
    assign s.awsize  = aw_size;
    assign s.awburst = aw_burst;
    assign s.awvalid = in_wr & aw_valid & ~aw_done;
    assign s.wdata   = w_data;
    assign s.wstrb   = w_strb;
    assign s.wlast   = w_last;
    assign s.wvalid  = in_wr & w_valid;
    assign s.bready  = in_wr & b_ready;

    logic rd0, rd1, wr0, wr1;
    assign rd0 = in_rd & ~gnt;
    assign rd1 = in_rd & gnt;
    assign wr0 = in_wr & ~gnt;
    assign wr1 = in_wr & gnt;

    // Responses and readies reach only the granted master; the other sees zeros.
    assign m0.arready = rd0 & ~ar_done & s.arready;
    assign m0.rvalid  = rd0 & s.rvalid;
    assign m0.rid     = rd0 ? s.rid : '0;
    assign m0.rdata   = rd0 ? s.rdata : '0;
    assign m0.rresp   = rd0 ? s.rresp : '0;
    assign m0.rlast   = rd0 & s.rlast;
    assign m0.awready = wr0 & ~aw_done & s.awready;
    assign m0.wready  = wr0 & s.wready;
    assign m0.bvalid  = wr0 & s.bvalid;
    assign m0.bid     = wr0 ? s.bid : '0;
    assign m0.bresp   = wr0 ? s.bresp : '0;

    assign m1.arready = rd1 & ~ar_done & s.arready;
    assign m1.rvalid  = rd1 & s.rvalid;
    assign m1.rid     = rd1 ? s.rid : '0;
    assign m1.rdata   = rd1 ? s.rdata : '0;
    assign m1.rresp   = rd1 ? s.rresp : '0;
    assign m1.rlast   = rd1 & s.rlast;
    assign m1.awready = wr1 & ~aw_done & s.awready;
    assign m1.wready  = wr1 & s.wready;
    assign m1.bvalid  = wr1 & s.bvalid;
    assign m1.bid     = wr1 ? s.bid : '0;
    assign m1.bresp   = wr1 ? s.bresp : '0;

endmodule

// File: tb/tb_axi4_arbiter.sv
// Directed bench for axi4_arbiter: reset, bursts, round-robin ties, write, mixed traffic, mid-burst reset.
module tb_axi4_arbiter;
  import axi_pkg::*;

  logic       clk;
  logic       rst_n;
  arb_state_t dbg_state;

  axi4_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(1)) m0_if ();
  axi4_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(1)) m1_if ();
  axi4_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(1)) s_if ();

  axi4_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .m0        (m0_if),
    .m1        (m1_if),
    .s         (s_if),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_pop(input string tag, input logic [31:0] obs);
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_underflow"}, 32'(exp_q.size()), 32'd1);
    end else begin
      got = exp_q.pop_front();
      chk(tag, obs, got);
    end
  endtask

  // driver tasks
  task automatic init_master(input int m);
    if (m == 0) begin
      m0_if.awid = '0; m0_if.awaddr = '0; m0_if.awlen = '0; m0_if.awsize = '0; m0_if.awburst = '0;
      m0_if.awvalid = 1'b0; m0_if.wdata = '0; m0_if.wstrb = '0; m0_if.wlast = 1'b0; m0_if.wvalid = 1'b0;
      m0_if.bready = 1'b0; m0_if.arid = '0; m0_if.araddr = '0; m0_if.arlen = '0; m0_if.arsize = '0;
      m0_if.arburst = '0; m0_if.arvalid = 1'b0; m0_if.rready = 1'b0;
    end else begin
      m1_if.awid = '0; m1_if.awaddr = '0; m1_if.awlen = '0; m1_if.awsize = '0; m1_if.awburst = '0;
      m1_if.awvalid = 1'b0; m1_if.wdata = '0; m1_if.wstrb = '0; m1_if.wlast = 1'b0; m1_if.wvalid = 1'b0;
      m1_if.bready = 1'b0; m1_if.arid = '0; m1_if.araddr = '0; m1_if.arlen = '0; m1_if.arsize = '0;
      m1_if.arburst = '0; m1_if.arvalid = 1'b0; m1_if.rready = 1'b0;
    end
  endtask

  task automatic set_ar(input int m, input logic v, input logic [31:0] addr, input logic [7:0] len);
    if (m == 0) begin
      m0_if.arvalid = v; m0_if.araddr = addr; m0_if.arlen = len;
      m0_if.arsize = 3'd2; m0_if.arburst = BURST_INCR;
    end else begin
      m1_if.arvalid = v; m1_if.araddr = addr; m1_if.arlen = len;
      m1_if.arsize = 3'd2; m1_if.arburst = BURST_INCR;
    end
  endtask

  task automatic slave_r(input logic v, input logic [31:0] data, input logic lst);
    s_if.rvalid = v; s_if.rdata = data; s_if.rlast = lst; s_if.rresp = RESP_OKAY; s_if.rid = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    init_master(0);
    init_master(1);
    s_if.awready = 1'b0; s_if.wready = 1'b0; s_if.arready = 1'b0;
    s_if.bvalid = 1'b0; s_if.bid = '0; s_if.bresp = RESP_OKAY;
    slave_r(1'b0, 32'h0, 1'b0);

    // reset held 2 cycles with a pending m0 read
    set_ar(0, 1'b1, 32'h8000_0000, 8'd3);
    tick();
    tick();
    chk("rst_s_arvalid", 32'(s_if.arvalid), 32'd0);
    chk("rst_m0_arready", 32'(m0_if.arready), 32'd0);
    chk("rst_m0_rvalid", 32'(m0_if.rvalid), 32'd0);
    chk("rst_m1_rvalid", 32'(m1_if.rvalid), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    rst_n = 1'b1;
    settle();
    chk("rel_s_arvalid", 32'(s_if.arvalid), 32'd0);

    // single 4-beat read from m0
    tick();
    chk("rd_s_arvalid", 32'(s_if.arvalid), 32'd1);
    chk("rd_s_araddr", s_if.araddr, 32'h8000_0000);
    chk("rd_s_arlen", 32'(s_if.arlen), 32'd3);
    chk("rd_state", 32'(dbg_state), 32'(RD));
    s_if.arready = 1'b1;
    settle();
    chk("rd_m0_arready", 32'(m0_if.arready), 32'd1);
    chk("rd_m1_arready", 32'(m1_if.arready), 32'd0);
    tick();
    set_ar(0, 1'b0, 32'h0, 8'd0);
    s_if.arready = 1'b0;
    m0_if.rready = 1'b1;
    settle();
    chk("rd_ar_once", 32'(s_if.arvalid), 32'd0);
    for (int k = 0; k < 4; k++) begin
      slave_r(1'b1, 32'(17 * (k + 1)), k == 3);
      exp_q.push_back(32'(17 * (k + 1)));
      settle();
      chk("rd_m1_rvalid", 32'(m1_if.rvalid), 32'd0);
      if (m0_if.rvalid && m0_if.rready) sb_pop("rd_beat", m0_if.rdata);
      else chk("rd_beat_valid", 32'(m0_if.rvalid), 32'd1);
      chk("rd_rlast", 32'(m0_if.rlast), 32'(k == 3));
      tick();
    end
    settle();
    chk("rd_end_state", 32'(dbg_state), 32'(IDLE));
    chk("rd_end_m0_rvalid", 32'(m0_if.rvalid), 32'd0);
    chk("rd_end_s_rready", 32'(s_if.rready), 32'd0);
    slave_r(1'b0, 32'h0, 1'b0);

    // round-robin ties after a fresh reset: m0, m1, m0
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    set_ar(0, 1'b1, 32'h100, 8'd0);
    set_ar(1, 1'b1, 32'h200, 8'd0);
    m0_if.rready = 1'b1;
    m1_if.rready = 1'b1;
    for (int r = 0; r < 3; r++) begin
      tick();
      s_if.arready = 1'b1;
      settle();
      chk("tie_araddr", s_if.araddr, (r % 2 == 1) ? 32'h200 : 32'h100);
      chk("tie_win_arready", 32'((r % 2 == 1) ? m1_if.arready : m0_if.arready), 32'd1);
      chk("tie_lose_arready", 32'((r % 2 == 1) ? m0_if.arready : m1_if.arready), 32'd0);
      tick();
      s_if.arready = 1'b0;
      slave_r(1'b1, 32'(r), 1'b1);
      settle();
      chk("tie_win_rvalid", 32'((r % 2 == 1) ? m1_if.rvalid : m0_if.rvalid), 32'd1);
      chk("tie_lose_rvalid", 32'((r % 2 == 1) ? m0_if.rvalid : m1_if.rvalid), 32'd0);
      tick();
      slave_r(1'b0, 32'h0, 1'b0);
      settle();
      chk("tie_idle", 32'(dbg_state), 32'(IDLE));
    end
    set_ar(0, 1'b0, 32'h0, 8'd0);
    set_ar(1, 1'b0, 32'h0, 8'd0);

    // m1 single-beat write with AW stalled 3 cycles
    m1_if.awvalid = 1'b1; m1_if.awaddr = 32'hA000_0000; m1_if.awlen = 8'd0;
    m1_if.awsize = 3'd2; m1_if.awburst = BURST_INCR;
    m1_if.wvalid = 1'b1; m1_if.wdata = 32'hDEAD_BEEF; m1_if.wstrb = 4'hF; m1_if.wlast = 1'b1;
    m1_if.bready = 1'b1;
    tick();
    chk("wr_state", 32'(dbg_state), 32'(WR));
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("wr_awvalid_hold", 32'(s_if.awvalid), 32'd1);
      chk("wr_awaddr", s_if.awaddr, 32'hA000_0000);
      chk("wr_m1_awready", 32'(m1_if.awready), 32'd0);
      tick();
    end
    s_if.awready = 1'b1;
    s_if.wready = 1'b1;
    settle();
    chk("wr_m1_awready_hs", 32'(m1_if.awready), 32'd1);
    chk("wr_m1_wready", 32'(m1_if.wready), 32'd1);
    chk("wr_m0_awready", 32'(m0_if.awready), 32'd0);
    chk("wr_wdata", s_if.wdata, 32'hDEAD_BEEF);
    chk("wr_wstrb", 32'(s_if.wstrb), 32'hF);
    tick();
    s_if.wready = 1'b0;
    m1_if.wvalid = 1'b0;
    settle();
    chk("wr_aw_once", 32'(s_if.awvalid), 32'd0);
    s_if.awready = 1'b0;
    m1_if.awvalid = 1'b0;
    s_if.bvalid = 1'b1;
    s_if.bresp = RESP_OKAY;
    exp_q.push_back(32'(RESP_OKAY));
    settle();
    chk("wr_m0_bvalid", 32'(m0_if.bvalid), 32'd0);
    if (m1_if.bvalid && m1_if.bready) sb_pop("wr_bresp", 32'(m1_if.bresp));
    else chk("wr_bvalid", 32'(m1_if.bvalid), 32'd1);
    tick();
    settle();
    chk("wr_end_state", 32'(dbg_state), 32'(IDLE));
    chk("wr_end_m1_bvalid", 32'(m1_if.bvalid), 32'd0);
    s_if.bvalid = 1'b0;

    // mixed: m1 read+write together, m0 arrives during the read
    set_ar(1, 1'b1, 32'h400, 8'd0);
    m1_if.awvalid = 1'b1; m1_if.awaddr = 32'hB000_0000;
    m1_if.wvalid = 1'b1; m1_if.wdata = 32'h1234_5678;
    tick();
    settle();
    chk("mix_rd_first", 32'(dbg_state), 32'(RD));
    chk("mix_m1_araddr", s_if.araddr, 32'h400);
    chk("mix_no_awvalid", 32'(s_if.awvalid), 32'd0);
    set_ar(0, 1'b1, 32'h300, 8'd0);
    s_if.arready = 1'b1;
    tick();
    s_if.arready = 1'b0;
    set_ar(1, 1'b0, 32'h0, 8'd0);
    slave_r(1'b1, 32'h55, 1'b1);
    tick();
    slave_r(1'b0, 32'h0, 1'b0);
    settle();
    chk("mix_idle1", 32'(dbg_state), 32'(IDLE));
    tick();
    settle();
    chk("mix_m0_state", 32'(dbg_state), 32'(RD));
    chk("mix_m0_araddr", s_if.araddr, 32'h300);
    chk("mix_m1_awready", 32'(m1_if.awready), 32'd0);
    s_if.arready = 1'b1;
    tick();
    s_if.arready = 1'b0;
    set_ar(0, 1'b0, 32'h0, 8'd0);
    slave_r(1'b1, 32'h66, 1'b1);
    settle();
    chk("mix_m0_rvalid", 32'(m0_if.rvalid), 32'd1);
    tick();
    slave_r(1'b0, 32'h0, 1'b0);
    tick();
    settle();
    chk("mix_wr_state", 32'(dbg_state), 32'(WR));
    chk("mix_awaddr", s_if.awaddr, 32'hB000_0000);
    chk("mix_wdata", s_if.wdata, 32'h1234_5678);
    s_if.awready = 1'b1;
    s_if.wready = 1'b1;
    tick();
    s_if.awready = 1'b0;
    s_if.wready = 1'b0;
    m1_if.awvalid = 1'b0;
    m1_if.wvalid = 1'b0;
    s_if.bvalid = 1'b1;
    tick();
    s_if.bvalid = 1'b0;

    // m0 read so that m1 would win the next tie unless reset restores last
    set_ar(0, 1'b1, 32'h500, 8'd0);
    tick();
    s_if.arready = 1'b1;
    tick();
    s_if.arready = 1'b0;
    set_ar(0, 1'b0, 32'h0, 8'd0);
    slave_r(1'b1, 32'h77, 1'b1);
    tick();
    slave_r(1'b0, 32'h0, 1'b0);

    // reset at beat 2 of a 4-beat m0 burst
    set_ar(0, 1'b1, 32'h600, 8'd3);
    tick();
    s_if.arready = 1'b1;
    tick();
    s_if.arready = 1'b0;
    set_ar(0, 1'b0, 32'h0, 8'd0);
    slave_r(1'b1, 32'hA1, 1'b0);
    tick();
    slave_r(1'b1, 32'hA2, 1'b0);
    rst_n = 1'b0;
    settle();
    chk("mrst_beat2", m0_if.rdata, 32'hA2);
    tick();
    settle();
    chk("mrst_state", 32'(dbg_state), 32'(IDLE));
    chk("mrst_m0_rvalid", 32'(m0_if.rvalid), 32'd0);
    chk("mrst_s_rready", 32'(s_if.rready), 32'd0);
    chk("mrst_m0_rdata", m0_if.rdata, 32'h0);
    slave_r(1'b0, 32'h0, 1'b0);
    rst_n = 1'b1;
    set_ar(0, 1'b1, 32'h100, 8'd0);
    set_ar(1, 1'b1, 32'h200, 8'd0);
    tick();
    settle();
    chk("mrst_tie_m0", s_if.araddr, 32'h100);

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
